// File: rtl/uart_memory_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_memory_loader_pkg
// Shared definitions for the UART memory loader: loader state enumeration,
// frame sync byte, frame field widths and small decode helpers used by both
// the top level and the byte fetcher.
// -----------------------------------------------------------------------------
package uart_memory_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Frame field widths
   localparam int BYTE_W  = 8;   // one UART character
   localparam int COUNT_W = 16;  // word count field (two bytes)
   localparam int WORD_W  = 32;  // memory word
   localparam int ADDR_W  = 32;  // memory byte address

   typedef enum logic [2:0] {
      WAIT_SYNC = 3'd0,
      LEN_LO    = 3'd1,
      LEN_HI    = 3'd2,
      DATA      = 3'd3,
      WRITE     = 3'd4,
      CHECK     = 3'd5,
      DONE      = 3'd6,
      ERROR     = 3'd7
   } state_t;

   // States that consume a received byte; the fetcher only pops in these.
   function automatic logic accepts_byte(input state_t s);
      return (s == WAIT_SYNC) || (s == LEN_LO) || (s == LEN_HI) ||
             (s == DATA) || (s == CHECK);
   endfunction

   // States in which the inter-byte timeout counter runs.
   function automatic logic timer_runs(input state_t s);
      return (s != WAIT_SYNC) && (s != DONE);
   endfunction

   // Byte address of a word: base + 4*index, 32-bit modulo.
   function automatic logic [ADDR_W-1:0] word_address(input logic [ADDR_W-1:0]  base,
                                                      input logic [COUNT_W-1:0] idx);
      return base + {{(ADDR_W-COUNT_W-2){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/uart_byte_fetcher.sv
// -----------------------------------------------------------------------------
// uart_byte_fetcher
// Pops bytes from the UART RX FIFO and presents each one for a single cycle.
// The FIFO returns data the cycle after the pop, so the popped byte is
// flagged as outstanding for exactly that one cycle, where it appears on
// byte_valid/byte_data.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   fetch_en       : consumer can accept a byte arriving after this pop
//   rx_fifo_empty  : FIFO empty flag
//   read_data      : FIFO data, valid the cycle after read
//   read           : registered one-cycle pop strobe
//   byte_valid     : a popped byte is on byte_data this cycle
//   byte_data      : the popped byte
// -----------------------------------------------------------------------------
module uart_byte_fetcher
   import uart_memory_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              rx_fifo_empty,
   input  logic [BYTE_W-1:0] read_data,
   output logic              read,
   output logic              byte_valid,
   output logic [BYTE_W-1:0] byte_data
);

   logic read_q, read_d;
   logic outstanding_q, outstanding_d;

   // A pop issued this cycle (read_q) has not returned yet, so never issue
   // back to back; the FIFO flag already reflects any earlier pop.
   always_comb begin
      read_d        = fetch_en && !rx_fifo_empty && !read_q;
      outstanding_d = read_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_q        <= 1'b0;
         outstanding_q <= 1'b0;
      end else begin
         read_q        <= read_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign read       = read_q;
   assign byte_valid = outstanding_q;
   assign byte_data  = read_data;

endmodule

// File: rtl/uart_memory_loader.sv
// -----------------------------------------------------------------------------
// uart_memory_loader
// Receives a program image over the UART RX FIFO and writes it into memory
// while holding the core in reset. Frame:
//   A5, count[7:0], count[15:8], 4*count data bytes (little-endian words),
//   checksum = XOR of all data bytes.
// A good checksum releases the core (terminal until reset); a bad checksum,
// oversized count or inter-byte timeout flags error and re-arms for a new
// sync byte. Words already written are left in memory.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   rx_fifo_empty  : UART RX FIFO empty flag
//   read           : one-cycle pop strobe to the FIFO
//   read_data      : RX byte, valid the cycle after read
//   memory_write   : one-cycle memory write strobe
//   address        : memory byte address (BASE_ADDRESS + 4*word index)
//   write_data     : memory write word
//   reset_core     : holds the core in reset until a successful load
//   enable_clk     : core clock enable after a successful load
//   busy           : frame in progress
//   done           : successful load (sticky until reset)
//   error          : failed frame (sticky until next sync byte)
// -----------------------------------------------------------------------------
module uart_memory_loader
   import uart_memory_loader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDRESS   = 32'h0000_0000,
   parameter int unsigned       MAX_WORDS      = 4096,
   parameter int unsigned       TIMEOUT_CYCLES = 25000000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_fifo_empty,
   output logic              read,
   input  logic [BYTE_W-1:0] read_data,
   output logic              memory_write,
   output logic [ADDR_W-1:0] address,
   output logic [WORD_W-1:0] write_data,
   output logic              reset_core,
   output logic              enable_clk,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [31:0] MAX_COUNT    = 32'(MAX_WORDS);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic [COUNT_W-1:0]   word_idx_q, word_idx_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [ADDR_W-1:0]    address_q, address_d;
   logic [BYTE_W-1:0]    checksum_q, checksum_d;
   logic [31:0]          timer_q, timer_d;
   logic                 error_q, error_d;

   logic                 byte_valid;
   logic [BYTE_W-1:0]    byte_data;
   logic                 fetch_en;
   logic                 timeout;
   logic                 last_word;
   logic [COUNT_W-1:0]   len_full;

   uart_byte_fetcher u_fetcher (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .rx_fifo_empty (rx_fifo_empty),
      .read_data     (read_data),
      .read          (read),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data)
   );

   // Full count as it becomes known on the high-byte cycle.
   assign len_full  = {byte_data, count_q[7:0]};
   assign last_word = (word_idx_q + 16'd1) == count_q;
   // An arriving byte resets the counter, so it also cancels a timeout.
   assign timeout   = timer_runs(state_q) && (timer_q == TIMEOUT_LAST) && !byte_valid;
   // Pops are decided one cycle ahead of the byte's arrival, so they follow
   // the state that will be current when the byte lands.
   assign fetch_en  = accepts_byte(state_d);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_SYNC: if (byte_valid && byte_data == SYNC_BYTE) state_d = LEN_LO;
         LEN_LO:    if (byte_valid) state_d = LEN_HI;
         LEN_HI: begin
            if (byte_valid) begin
               if (len_full == '0)
                  state_d = CHECK;
               else if ({16'd0, len_full} > MAX_COUNT)
                  state_d = ERROR;
               else
                  state_d = DATA;
            end
         end
         DATA:      if (byte_valid && byte_idx_q == 2'd3) state_d = WRITE;
         WRITE:     state_d = last_word ? CHECK : DATA;
         CHECK:     if (byte_valid) state_d = (byte_data == checksum_q) ? DONE : ERROR;
         DONE:      state_d = DONE;
         ERROR:     state_d = WAIT_SYNC;
      endcase
      if (timeout) state_d = ERROR;
   end

   // -------------------------------------------------------------------------
   // Output decode
   // -------------------------------------------------------------------------
   always_comb begin
      memory_write = (state_q == WRITE);
      busy         = (state_q != WAIT_SYNC) && (state_q != DONE) && (state_q != ERROR);
      done         = (state_q == DONE);
      reset_core   = (state_q != DONE);
      enable_clk   = (state_q == DONE);
   end

   assign address    = address_q;
   assign write_data = word_q;
   assign error      = error_q;

   // -------------------------------------------------------------------------
   // Datapath: count, word assembly, address, checksum, timeout, error flag
   // -------------------------------------------------------------------------
   always_comb begin
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      address_d  = address_q;
      checksum_d = checksum_q;
      error_d    = error_q;
      timer_d    = timer_q + 32'd1;
      if (!timer_runs(state_q) || byte_valid) timer_d = '0;

      case (state_q)
         WAIT_SYNC: begin
            if (byte_valid && byte_data == SYNC_BYTE) begin
               error_d    = 1'b0;
               checksum_d = '0;
               count_d    = '0;
            end
         end
         LEN_LO: if (byte_valid) count_d[7:0] = byte_data;
         LEN_HI: begin
            if (byte_valid) begin
               count_d[15:8] = byte_data;
               word_idx_d    = '0;
               byte_idx_d    = '0;
            end
         end
         DATA: begin
            if (byte_valid) begin
               word_d[{byte_idx_q, 3'b000} +: BYTE_W] = byte_data;
               checksum_d = checksum_q ^ byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
               // Latch the address with the final byte so address and data
               // are both settled for the whole write cycle.
               if (byte_idx_q == 2'd3) address_d = word_address(BASE_ADDRESS, word_idx_q);
            end
         end
         WRITE: word_idx_d = word_idx_q + 16'd1;
         default: ;
      endcase

      if (state_d == ERROR) error_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         address_q  <= BASE_ADDRESS;
         checksum_q <= '0;
         timer_q    <= '0;
         error_q    <= 1'b0;
      end else begin
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         address_q  <= address_d;
         checksum_q <= checksum_d;
         timer_q    <= timer_d;
         error_q    <= error_d;
      end
   end

endmodule

// File: tb/tb_uart_memory_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_memory_loader
// Directed and randomized frames fed through a queue-based RX FIFO model;
// expected memory writes and flags come from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_memory_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          MAXW = 4096;
   localparam int          TO   = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_fifo_empty;
   logic        read;
   logic [7:0]  read_data;
   logic        memory_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        reset_core;
   logic        enable_clk;
   logic        busy;
   logic        done;
   logic        error;

   always #5 clk = ~clk;

   uart_memory_loader #(
      .BASE_ADDRESS   (BASE),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_fifo_empty (rx_fifo_empty),
      .read          (read),
      .read_data     (read_data),
      .memory_write  (memory_write),
      .address       (address),
      .write_data    (write_data),
      .reset_core    (reset_core),
      .enable_clk    (enable_clk),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   logic [7:0]  fifo[$];
   logic [7:0]  frame[$];
   logic [7:0]  payload[$];
   logic [31:0] wr_addr[$], wr_data[$];
   logic [31:0] exp_addr[$], exp_data[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          cycle    = 0;
   int          last_pop_cycle = 0;
   bit          prev_read = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs on the falling edge, then serve a pop.
   task automatic tick();
      bit r;
      @(negedge clk);
      cycle++;
      r = read;
      if (memory_write) begin
         wr_addr.push_back(address);
         wr_data.push_back(write_data);
      end
      if (r && !reset) begin
         check1("pop_only_when_nonempty", fifo.size() != 0, 1'b1);
         check1("pop_spacing", prev_read, 1'b0);
      end
      prev_read = r;
      @(posedge clk);
      #1;
      if (r && fifo.size() > 0) begin
         read_data = fifo.pop_front();
         last_pop_cycle = cycle;
      end
      rx_fifo_empty = (fifo.size() == 0);
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      rx_fifo_empty = 1'b0;
   endtask

   task automatic push_frame();
      foreach (frame[i]) push(frame[i]);
   endtask

   // Reference model: frame bytes and expected writes from the payload.
   task automatic make_frame(input logic [15:0] cnt, input logic [7:0] ck_flip);
      logic [7:0] ck;
      ck = 8'h00;
      frame.delete();
      exp_addr.delete();
      exp_data.delete();
      frame.push_back(8'hA5);
      frame.push_back(cnt[7:0]);
      frame.push_back(cnt[15:8]);
      foreach (payload[i]) begin
         frame.push_back(payload[i]);
         ck = ck ^ payload[i];
      end
      frame.push_back(ck ^ ck_flip);
      for (int w = 0; w < payload.size() / 4; w++) begin
         exp_addr.push_back(BASE + 32'(4 * w));
         exp_data.push_back({payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]});
      end
   endtask

   task automatic random_payload(input int words);
      payload.delete();
      for (int i = 0; i < 4 * words; i++) payload.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_write_count"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
      end
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && !done; k++) tick();
      check1("done_within_budget", done, 1'b1);
   endtask

   task automatic wait_error(input int budget);
      for (int k = 0; k < budget && !error; k++) tick();
      check1("error_within_budget", error, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, "_read"}, read, 1'b0);
      check1({tag, "_memory_write"}, memory_write, 1'b0);
      check({tag, "_address"}, address, BASE);
      check({tag, "_write_data"}, write_data, 32'h0);
      check1({tag, "_reset_core"}, reset_core, 1'b1);
      check1({tag, "_enable_clk"}, enable_clk, 1'b0);
      check1({tag, "_busy"}, busy, 1'b0);
      check1({tag, "_done"}, done, 1'b0);
      check1({tag, "_error"}, error, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fifo.delete();
      rx_fifo_empty = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int delta;
      int cnt;
      int ngarb;
      logic [7:0] g;
      logic [7:0] flip;
      bit bad;

      reset = 1'b1;
      rx_fifo_empty = 1'b1;
      read_data = 8'h00;
      tick();
      tick();
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      // Two-word load with correct checksum.
      payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      make_frame(16'd2, 8'h00);
      push_frame();
      wait_done(300);
      check1("ok_done", done, 1'b1);
      check1("ok_error", error, 1'b0);
      check1("ok_reset_core", reset_core, 1'b0);
      check1("ok_enable_clk", enable_clk, 1'b1);
      check1("ok_busy", busy, 1'b0);
      check_writes("ok");
      check(  "ok_word0", exp_data[0], 32'h4433_2211);
      // Done is terminal: nothing further is popped.
      push(8'hA5);
      for (int k = 0; k < 10; k++) tick();
      check("done_no_pop", 32'(fifo.size()), 32'd1);
      check1("done_sticky", done, 1'b1);

      // Bad checksum, then recovery with a good frame.
      do_reset();
      make_frame(16'd2, 8'h88 ^ 8'h01);
      check("bad_ck_byte", 32'(frame[frame.size()-1]), 32'h01);
      push_frame();
      wait_error(300);
      check1("bad_error", error, 1'b1);
      check1("bad_done", done, 1'b0);
      check1("bad_reset_core", reset_core, 1'b1);
      check1("bad_enable_clk", enable_clk, 1'b0);
      check_writes("bad_kept");
      for (int k = 0; k < 5; k++) tick();
      check1("bad_error_sticky", error, 1'b1);
      check1("bad_busy", busy, 1'b0);
      wr_addr.delete();
      wr_data.delete();
      make_frame(16'd2, 8'h00);
      push_frame();
      wait_done(300);
      check1("recover_error", error, 1'b0);
      check1("recover_done", done, 1'b1);
      check_writes("recover");

      // Garbage before sync, zero-length frame.
      do_reset();
      push(8'h00);
      push(8'hFF);
      payload.delete();
      make_frame(16'd0, 8'h00);
      push_frame();
      wait_done(200);
      check1("zero_done", done, 1'b1);
      check1("zero_error", error, 1'b0);
      check_writes("zero");

      // Oversized count.
      do_reset();
      payload.delete();
      make_frame(16'h1001, 8'h00);
      push_frame();
      wait_error(200);
      check1("big_error", error, 1'b1);
      check1("big_done", done, 1'b0);
      check1("big_busy", busy, 1'b0);
      check("big_write_count", 32'(wr_addr.size()), 32'd0);

      // Stall after three data bytes.
      do_reset();
      push(8'hA5); push(8'h01); push(8'h00);
      push(8'h11); push(8'h22); push(8'h33);
      for (int k = 0; k < 400 && !error; k++) begin
         tick();
         if (fifo.size() == 0 && cycle - last_pop_cycle == 90) begin
            check1("stall_no_early_error", error, 1'b0);
            check1("stall_busy", busy, 1'b1);
         end
      end
      delta = cycle - last_pop_cycle;
      check1("stall_error", error, 1'b1);
      check1("stall_latency_window", (delta >= 98) && (delta <= 104), 1'b1);
      check1("stall_busy_after", busy, 1'b0);
      check("stall_write_count", 32'(wr_addr.size()), 32'd0);

      // Reset in the middle of the data phase.
      do_reset();
      push(8'hA5); push(8'h02); push(8'h00);
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      for (int k = 0; k < 40 && fifo.size() != 0; k++) tick();
      tick();
      check1("mid_busy", busy, 1'b1);
      reset = 1'b1;
      fifo.delete();
      rx_fifo_empty = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      reset = 1'b0;
      wr_addr.delete();
      wr_data.delete();
      random_payload(3);
      make_frame(16'd3, 8'h00);
      push_frame();
      wait_done(400);
      check1("mid_fresh_done", done, 1'b1);
      check_writes("mid_fresh");

      // Randomized frames with leading garbage and occasional bad checksum.
      for (int it = 0; it < 6; it++) begin
         do_reset();
         cnt   = $urandom_range(1, 6);
         ngarb = $urandom_range(0, 3);
         bad   = ($urandom_range(0, 3) == 0);
         flip  = bad ? 8'($urandom_range(1, 255)) : 8'h00;
         for (int i = 0; i < ngarb; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            push(g);
         end
         random_payload(cnt);
         make_frame(16'(cnt), flip);
         push_frame();
         if (bad) begin
            wait_error(600);
            check1($sformatf("rnd%0d_done", it), done, 1'b0);
         end else begin
            wait_done(600);
            check1($sformatf("rnd%0d_error", it), error, 1'b0);
         end
         check_writes($sformatf("rnd%0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
